// File: rtl/id_stage_piped_if.sv
// ID/EX pipeline bundle: registered decode controls and operands handed to EXE.
interface id_stage_piped_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);
  logic              ex_valid;
  logic              ex_wb_en;
  logic              ex_mem_r_en;
  logic              ex_mem_w_en;
  logic              ex_b;
  logic              ex_s;
  logic [3:0]        ex_exe_cmd;
  logic [DATA_W-1:0] ex_val_rn;
  logic [DATA_W-1:0] ex_val_rm;
  logic              ex_imm;
  logic [11:0]       ex_shift_operand;
  logic [23:0]       ex_signed_imm_24;
  logic [3:0]        ex_dest;
  logic [3:0]        ex_src1;
  logic [3:0]        ex_src2;
  logic [PC_W-1:0]   ex_pc;

  modport master (
    output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd,
           ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand, ex_signed_imm_24,
           ex_dest, ex_src1, ex_src2, ex_pc
  );

  modport slave (
    input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd,
           ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand, ex_signed_imm_24,
           ex_dest, ex_src1, ex_src2, ex_pc
  );
endinterface

// File: rtl/id_stage_piped.sv
// Instruction decode stage for the ARM subset: condition check, control decode,
// bypassed register file read, and the ID/EX pipeline register.
module id_stage_piped #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              in_valid,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        sr,
  input  logic              hazard,
  input  logic              freeze,
  input  logic              flush,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  id_stage_piped_if.master  ex
);

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  logic [DATA_W-1:0] rf [NREGS];

  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;
  logic        is_str;
  logic        cond_ok;
  exe_cmd_e    d_cmd;
  logic        d_wb, d_mem_r, d_mem_w, d_b, d_s;
  logic [DATA_W-1:0] val_rn, val_rm;
  logic        n_f, z_f, c_f, v_f;

  assign mode    = instr_in[27:26];
  assign opcode  = instr_in[24:21];
  assign s_bit   = instr_in[20];
  assign is_str  = (mode == 2'b01) && !s_bit;
  assign src1    = instr_in[19:16];
  assign src2    = is_str ? instr_in[15:12] : instr_in[3:0];
  assign two_src = ~instr_in[25] | is_str;
  assign {n_f, z_f, c_f, v_f} = sr;

  // Evaluate the condition field against the status flags.
  always_comb begin
    cond_ok = 1'b0;
    case (instr_in[31:28])
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Decode mode/opcode into EXE command and control bits.
  always_comb begin
    d_cmd   = CMD_NOP;
    d_wb    = 1'b0;
    d_mem_r = 1'b0;
    d_mem_w = 1'b0;
    d_b     = 1'b0;
    d_s     = 1'b0;
    case (mode)
      2'b00: begin
        case (opcode)
          4'b1101: d_cmd = CMD_MOV;
          4'b1111: d_cmd = CMD_MVN;
          4'b0100: d_cmd = CMD_ADD;
          4'b0101: d_cmd = CMD_ADC;
          4'b0010: d_cmd = CMD_SUB;
          4'b0110: d_cmd = CMD_SBC;
          4'b0000: d_cmd = CMD_AND;
          4'b1100: d_cmd = CMD_ORR;
          4'b0001: d_cmd = CMD_EOR;
          4'b1010: d_cmd = CMD_SUB;
          4'b1000: d_cmd = CMD_AND;
          default: d_cmd = CMD_NOP;
        endcase
        // CMP/TST only set flags; every other recognised opcode writes back.
        if (opcode == 4'b1010 || opcode == 4'b1000) begin
          d_s = 1'b1;
        end else if (d_cmd != CMD_NOP) begin
          d_wb = 1'b1;
          d_s  = s_bit;
        end
      end
      2'b01: begin
        d_cmd   = CMD_ADD;
        d_mem_r = s_bit;
        d_wb    = s_bit;
        d_mem_w = !s_bit;
      end
      2'b10: d_b = 1'b1;
      default: ;
    endcase
  end

  // Register file read with same-cycle write-back bypass; out-of-range reads give 0.
  always_comb begin
    val_rn = '0;
    val_rm = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (src1 == i[3:0]) val_rn = (wb_en && wb_dest == src1) ? wb_value : rf[i];
      if (src2 == i[3:0]) val_rm = (wb_en && wb_dest == src2) ? wb_value : rf[i];
    end
  end

  // Register file write; never blocked by pipeline control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wb_en && wb_dest == i[3:0]) rf[i] <= wb_value;
      end
    end
  end

  // ID/EX register: flush beats freeze; hazard/invalid/failed condition inject a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.ex_valid         <= 1'b0;
      ex.ex_wb_en         <= 1'b0;
      ex.ex_mem_r_en      <= 1'b0;
      ex.ex_mem_w_en      <= 1'b0;
      ex.ex_b             <= 1'b0;
      ex.ex_s             <= 1'b0;
      ex.ex_exe_cmd       <= '0;
      ex.ex_val_rn        <= '0;
      ex.ex_val_rm        <= '0;
      ex.ex_imm           <= 1'b0;
      ex.ex_shift_operand <= '0;
      ex.ex_signed_imm_24 <= '0;
      ex.ex_dest          <= '0;
      ex.ex_src1          <= '0;
      ex.ex_src2          <= '0;
      ex.ex_pc            <= '0;
    end else if (flush || !freeze) begin
      ex.ex_val_rn        <= val_rn;
      ex.ex_val_rm        <= val_rm;
      ex.ex_imm           <= instr_in[25];
      ex.ex_shift_operand <= instr_in[11:0];
      ex.ex_signed_imm_24 <= instr_in[23:0];
      ex.ex_dest          <= instr_in[15:12];
      ex.ex_src1          <= src1;
      ex.ex_src2          <= src2;
      ex.ex_pc            <= pc_in;
      if (flush || hazard || !in_valid || !cond_ok) begin
        ex.ex_valid    <= 1'b0;
        ex.ex_wb_en    <= 1'b0;
        ex.ex_mem_r_en <= 1'b0;
        ex.ex_mem_w_en <= 1'b0;
        ex.ex_b        <= 1'b0;
        ex.ex_s        <= 1'b0;
        ex.ex_exe_cmd  <= '0;
      end else begin
        ex.ex_valid    <= 1'b1;
        ex.ex_wb_en    <= d_wb;
        ex.ex_mem_r_en <= d_mem_r;
        ex.ex_mem_w_en <= d_mem_w;
        ex.ex_b        <= d_b;
        ex.ex_s        <= d_s;
        ex.ex_exe_cmd  <= d_cmd;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_piped.sv
// Directed bench for id_stage_piped: decode, bypass, condition, stall/flush, reset.
module tb_id_stage_piped;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  sr;
  logic        hazard, freeze, flush;
  logic [3:0]  src1, src2, src1_8, src2_8;
  logic        two_src, two_src_8;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  id_stage_piped_if #(.DATA_W(32), .PC_W(32)) ex16 ();
  id_stage_piped_if #(.DATA_W(32), .PC_W(32)) ex8 ();

  id_stage_piped #(.DATA_W(32), .PC_W(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .in_valid(in_valid),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .sr(sr),
    .hazard(hazard), .freeze(freeze), .flush(flush),
    .src1(src1), .src2(src2), .two_src(two_src), .ex(ex16.master)
  );

  id_stage_piped #(.DATA_W(32), .PC_W(32), .NREGS(8)) dut8 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .in_valid(in_valid),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .sr(sr),
    .hazard(hazard), .freeze(freeze), .flush(flush),
    .src1(src1_8), .src2(src2_8), .two_src(two_src_8), .ex(ex8.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins;
    pc_in    = pc;
    in_valid = 1'b1;
  endtask

  task automatic write_reg(input logic [3:0] d, input logic [31:0] v);
    wb_en = 1'b1; wb_dest = d; wb_value = v;
  endtask

  initial begin
    rst = 1'b1; instr_in = '0; pc_in = '0; in_valid = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0; sr = 4'b0000;
    hazard = 1'b0; freeze = 1'b0; flush = 1'b0;

    // Reset state; combinational decode still follows instr_in.
    #3;
    instr_in = 32'hE580_1000;
    #1;
    check("rst_valid", ex16.ex_valid, 0);
    check("rst_cmd", ex16.ex_exe_cmd, 0);
    check("rst_pc", ex16.ex_pc, 0);
    check("rst_str_src2", src2, 1);
    check("rst_str_two_src", two_src, 1);

    // Release reset between edges; first edge loads STR normally.
    #8;
    rst = 1'b0;
    drive(32'hE580_1000, 32'h100);
    tick();
    check("str_valid", ex16.ex_valid, 1);
    check("str_mem_w", ex16.ex_mem_w_en, 1);
    check("str_wb", ex16.ex_wb_en, 0);
    check("str_cmd", ex16.ex_exe_cmd, 4'b0010);

    // LDR
    drive(32'hE590_1000, 32'h104);
    tick();
    check("ldr_mem_r", ex16.ex_mem_r_en, 1);
    check("ldr_wb", ex16.ex_wb_en, 1);
    check("ldr_mem_w", ex16.ex_mem_w_en, 0);
    check("ldr_s", ex16.ex_s, 0);

    // Fill R2=7, R3=5 with bubbles in the pipe.
    in_valid = 1'b0;
    write_reg(4'd2, 32'd7);
    tick();
    write_reg(4'd3, 32'd5);
    tick();
    check("inv_bubble", ex16.ex_valid, 0);
    wb_en = 1'b0;

    // ADD R1,R2,R3
    drive(32'hE082_1003, 32'h108);
    #1;
    check("add_two_src", two_src, 1);
    check("add_src2", src2, 3);
    tick();
    check("add_cmd", ex16.ex_exe_cmd, 4'b0010);
    check("add_wb", ex16.ex_wb_en, 1);
    check("add_rn", ex16.ex_val_rn, 7);
    check("add_rm", ex16.ex_val_rm, 5);
    check("add_dest", ex16.ex_dest, 1);
    check("add_pc", ex16.ex_pc, 32'h108);

    // MOV R0,#5 while writing R0=9
    drive(32'hE3A0_0005, 32'h10C);
    write_reg(4'd0, 32'd9);
    tick();
    check("mov_cmd", ex16.ex_exe_cmd, 4'b0001);
    check("mov_imm", ex16.ex_imm, 1);
    check("mov_shift", ex16.ex_shift_operand, 12'h005);
    wb_en = 1'b0;

    // ADD R4,R0,R0 reads committed R0
    drive(32'hE080_4000, 32'h110);
    tick();
    check("r0_rn", ex16.ex_val_rn, 9);
    check("r0_rm", ex16.ex_val_rm, 9);
    check("r0_dest", ex16.ex_dest, 4);

    // Bypass: read R2 while writing R2=0x55
    drive(32'hE082_1003, 32'h114);
    write_reg(4'd2, 32'h55);
    tick();
    check("bypass_rn", ex16.ex_val_rn, 32'h55);
    check("bypass_rm", ex16.ex_val_rm, 5);
    wb_en = 1'b0;

    // CMP R1,R2: flags only
    drive(32'hE151_0002, 32'h118);
    tick();
    check("cmp_cmd", ex16.ex_exe_cmd, 4'b0100);
    check("cmp_wb", ex16.ex_wb_en, 0);
    check("cmp_s", ex16.ex_s, 1);

    // MOVEQ with Z clear, then with Z set
    drive(32'h03A0_0005, 32'h11C);
    sr = 4'b0000;
    tick();
    check("moveq_z0_valid", ex16.ex_valid, 0);
    check("moveq_z0_wb", ex16.ex_wb_en, 0);
    sr = 4'b0100;
    tick();
    check("moveq_z1_wb", ex16.ex_wb_en, 1);
    check("moveq_z1_cmd", ex16.ex_exe_cmd, 4'b0001);
    sr = 4'b0000;

    // Condition 1111 never executes
    drive(32'hF082_1003, 32'h120);
    tick();
    check("nv_valid", ex16.ex_valid, 0);

    // Branch
    drive(32'hEA00_0010, 32'h124);
    tick();
    check("b_b", ex16.ex_b, 1);
    check("b_imm24", ex16.ex_signed_imm_24, 24'h00_0010);

    // Load ADD R1,R2,R3 (R2=0x55), then freeze 3 cycles with changing instr and a pending write
    drive(32'hE082_1003, 32'h128);
    tick();
    freeze = 1'b1;
    write_reg(4'd5, 32'h77);
    for (int k = 0; k < 3; k++) begin
      drive(32'hE3A0_0005 + k, 32'h200 + k);
      tick();
      check("frz_cmd", ex16.ex_exe_cmd, 4'b0010);
      check("frz_rn", ex16.ex_val_rn, 32'h55);
      check("frz_imm", ex16.ex_imm, 0);
      check("frz_pc", ex16.ex_pc, 32'h128);
    end
    freeze = 1'b0;
    wb_en = 1'b0;

    // Write during freeze committed: ADD R1,R5,R3
    drive(32'hE085_1003, 32'h12C);
    tick();
    check("frz_wr_commit", ex16.ex_val_rn, 32'h77);
    check("frz_wr_valid", ex16.ex_valid, 1);

    // freeze + flush: flush wins
    freeze = 1'b1; flush = 1'b1;
    drive(32'hE082_1003, 32'h130);
    tick();
    check("flush_valid", ex16.ex_valid, 0);
    check("flush_cmd", ex16.ex_exe_cmd, 0);
    check("flush_pc", ex16.ex_pc, 32'h130);
    freeze = 1'b0; flush = 1'b0;

    // hazard bubble
    hazard = 1'b1;
    tick();
    check("haz_valid", ex16.ex_valid, 0);
    check("haz_wb", ex16.ex_wb_en, 0);
    hazard = 1'b0;

    // Eight-entry instance: R12 out of range reads 0, R7 in range.
    drive(32'hE08C_100C, 32'h134);
    write_reg(4'd12, 32'hAB);
    tick();
    check("n8_r12_bypass", ex8.ex_val_rn, 0);
    check("n16_r12_bypass", ex16.ex_val_rn, 32'hAB);
    wb_en = 1'b0;
    tick();
    check("n8_r12_read", ex8.ex_val_rn, 0);
    check("n16_r12_read", ex16.ex_val_rn, 32'hAB);
    drive(32'hE087_1007, 32'h138);
    write_reg(4'd7, 32'h11);
    tick();
    wb_en = 1'b0;
    tick();
    check("n8_r7_read", ex8.ex_val_rm, 32'h11);

    // Asynchronous reset mid-stream, checked before the next edge
    drive(32'hE082_1003, 32'h13C);
    tick();
    check("pre_rst_valid", ex16.ex_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", ex16.ex_valid, 0);
    check("arst_wb", ex16.ex_wb_en, 0);
    check("arst_rn", ex16.ex_val_rn, 0);
    check("arst_dest", ex16.ex_dest, 0);
    check("arst_pc", ex16.ex_pc, 0);
    check("arst_src1_comb", src1, 2);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_valid", ex16.ex_valid, 1);
    check("post_rst_rf_clear", ex16.ex_val_rn, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage_piped.md
# id_stage_piped

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, write-through register file, and stall/flush control. It sits between the IF/ID register and the EXE stage. It decodes the 32-bit ARM-subset instruction, evaluates the condition field against the status register, and reads operands. Every EXE-facing output is registered, with one-cycle latency. Hazard, freeze and flush each inject a bubble or hold the stage.

## Interface
- DATA_W, 32: register/operand width.
- PC_W, 32: width of the PC carried alongside the instruction.
- NREGS, 16: implemented registers, 1..16. Index ≥ NREGS reads 0; writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_in  in  32  instruction from IF/ID
- pc_in  in  PC_W  PC of instr_in
- in_valid  in  1  instr_in is real, not a bubble
- wb_en  in  1  write-back enable
- wb_dest  in  4  write-back register index
- wb_value  in  DATA_W  write-back data
- sr  in  4  status {N,Z,C,V}
- hazard  in  1  load-use/RAW hazard from hazard unit
- freeze  in  1  downstream stall; hold ID/EX register
- flush  in  1  taken branch; kill instruction in ID
- src1  out  4  instr_in[19:16], combinational
- src2  out  4  mem write ? instr_in[15:12] : instr_in[3:0], combinational
- two_src  out  1  ~instr_in[25] | (decoded STR), combinational
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1 each  registered controls
- ex_exe_cmd  out  4  ALU command
- ex_val_rn, ex_val_rm  out  DATA_W  operand values
- ex_imm  out  1  instr[25]
- ex_shift_operand  out  12  instr[11:0]
- ex_signed_imm_24  out  24  instr[23:0]
- ex_dest, ex_src1, ex_src2  out  4  register indices
- ex_pc  out  PC_W  PC of the instruction

## Operation
- Mode is instr[27:26]; opcode is instr[24:21]; S is instr[20].
- Mode 00 data-processing opcode to exe_cmd and wb:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000: all wb=1.
  - CMP 1010→0100 and TST 1000→0110: wb=0, s forced 1.
  - Any other opcode: all controls 0.
- Mode 01: exe_cmd=0010. S=1 is LDR (mem_r, wb, s=0). S=0 is STR (mem_w, s=0).
- Mode 10: b=1, all other controls 0. Mode 11: all controls 0.
- Condition is instr[31:28], standard ARM EQ..AL; 1111 is never true. cond_ok gates every control bit.
- Register file:
  - NREGS×DATA_W storage, written on the rising edge when wb_en is high.
  - Read is combinational with bypass: if wb_en and wb_dest == read index (< NREGS), the read returns wb_value in the same cycle.
- Pipeline register update, in priority order:
  1. flush: load bubble.
  2. freeze: hold all ex_* values.
  3. hazard, or !in_valid, or !cond_ok: load bubble.
  4. Otherwise load the decoded instruction, with ex_valid=1.
- Bubble means ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s and ex_exe_cmd are all 0. Datapath fields still load; they are don't-care.
- The register file write is never blocked by freeze, flush or hazard.

## Timing
- rst asserted: every ex_* output and every register-file entry becomes 0 immediately. Combinational outputs still follow instr_in.
- Latency: the instruction presented in cycle n appears on ex_* after edge n+1.
- Write-back and a read of the same register in the same cycle: the read returns the new value, via the bypass.
- freeze held k cycles: ex_* stays constant for k edges, and a pending register-file write still commits.
- flush and freeze together: flush wins, and a bubble loads.
- Reset released mid-stream: the first edge after release loads normally.

## Test plan
- Reset, then ADD R1,R2,R3 (0xE0821003) with R2=7, R3=5, in_valid=1 → next edge: ex_exe_cmd=0010, ex_wb_en=1, ex_val_rn=7, ex_val_rm=5, ex_dest=1, two_src=1.
- MOV R0,#5 (0xE3A00005) while wb_en=1, wb_dest=0, wb_value=9 → ex_exe_cmd=0001, ex_imm=1, ex_shift_operand=0x005. Then read R0 via ADD R4,R0,R0 → ex_val_rn=9. Separately, bypass: read of R2 while writing R2=0x55 in the same cycle → ex_val_rn=0x55.
- MOVEQ 0x03A00005 with sr=0000 → bubble (ex_valid=0, ex_wb_en=0). Same instruction with sr=0100 → ex_wb_en=1.
- STR R1,[R0] (0xE5801000) → src2=1, two_src=1, ex_mem_w_en=1, ex_wb_en=0. LDR (0xE5901000) → ex_mem_r_en=1, ex_wb_en=1.
- Load ADD, then freeze=1 for 3 cycles while instr changes → ex_* unchanged for 3 edges. Then freeze+flush together → bubble. Then hazard=1 → bubble, ex_valid=0.
- NREGS=8: write R12=0xAB, then read R12 → 0. Assert rst mid-stream → all ex_* outputs 0 asynchronously, before the next edge.
